// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: op codes, sequencer state
// encodings and small op-classification helpers.
package alu_pkg;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_NOR    = 4'b0100;
    localparam logic [3:0] ALU_XOR    = 4'b0101;
    localparam logic [3:0] ALU_XNOR   = 4'b0110;
    localparam logic [3:0] ALU_NAND   = 4'b0111;
    localparam logic [3:0] ALU_PASS_A = 4'b1000;
    localparam logic [3:0] ALU_PASS_B = 4'b1001;
    localparam logic [3:0] ALU_ZERO   = 4'b1010;
    localparam logic [3:0] ALU_SLT    = 4'b1011;
    localparam logic [3:0] ALU_SLTU   = 4'b1100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Subtract-style ops feed ~b with a carry-in of 1.
    function automatic logic op_inverts_b(input logic [3:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

    function automatic logic op_is_arith(input logic [3:0] op);
        return (op == ALU_ADD) || op_inverts_b(op);
    endfunction

    function automatic logic op_has_ovf(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice; in MSB mode it also yields the
// signed and unsigned less-than bits.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic [3:0] op,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       is_msb,
    output logic       result,
    output logic       cout,
    output logic       slt_bit,
    output logic       sltu_bit
);

    logic b_eff;
    logic sum;
    logic carry;

    always_comb begin
        b_eff  = b ^ op_inverts_b(op);
        sum    = a ^ b_eff ^ cin;
        carry  = (a & b_eff) | (a & cin) | (b_eff & cin);
        result = 1'b0;
        cout   = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU: begin
                result = sum;
                cout   = carry;
            end
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_NOR:    result = ~(a | b);
            ALU_XOR:    result = a ^ b;
            ALU_XNOR:   result = ~(a ^ b);
            ALU_NAND:   result = ~(a & b);
            ALU_PASS_A: result = a;
            ALU_PASS_B: result = b;
            default:    result = 1'b0;
        endcase
        // Signed less-than is the sign of the true difference: ovf ^ sum.
        slt_bit  = is_msb & ((cin ^ carry) ^ sum);
        sltu_bit = is_msb & ~carry;
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: accepts one op, runs it LSB first through a
// single alu_bit_slice over WIDTH cycles, then holds the result until taken.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic [1:0]       state_reg, state_next;
    logic [3:0]       op_reg, op_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic             carry_reg, carry_next;
    logic [CNT_W-1:0] bit_idx_reg, bit_idx_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg, ovf_next;

    logic is_msb;
    logic slice_result;
    logic slice_cout;
    logic slice_slt;
    logic slice_sltu;

    assign is_msb = (bit_idx_reg == LAST_IDX);

    alu_bit_slice u_slice (
        .op       (op_reg),
        .a        (a_reg[0]),
        .b        (b_reg[0]),
        .cin      (carry_reg),
        .is_msb   (is_msb),
        .result   (slice_result),
        .cout     (slice_cout),
        .slt_bit  (slice_slt),
        .sltu_bit (slice_sltu)
    );

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        res_next     = res_reg;
        carry_next   = carry_reg;
        bit_idx_next = bit_idx_reg;
        cout_next    = cout_reg;
        ovf_next     = ovf_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    op_next      = in_op;
                    a_next       = in_a;
                    b_next       = in_b;
                    res_next     = '0;
                    carry_next   = op_inverts_b(in_op);
                    bit_idx_next = '0;
                    cout_next    = 1'b0;
                    ovf_next     = 1'b0;
                    state_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                a_next       = a_reg >> 1;
                b_next       = b_reg >> 1;
                res_next     = {slice_result, res_reg[WIDTH-1:1]};
                carry_next   = slice_cout;
                bit_idx_next = bit_idx_reg + 1'b1;
                if (is_msb) begin
                    // Compare ops discard the shifted sum in favour of one flag bit.
                    if (op_reg == ALU_SLT) begin
                        res_next = WIDTH'(slice_slt);
                    end else if (op_reg == ALU_SLTU) begin
                        res_next = WIDTH'(slice_sltu);
                    end
                    cout_next  = op_is_arith(op_reg) & slice_cout;
                    ovf_next   = op_has_ovf(op_reg) & (carry_reg ^ slice_cout);
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            op_reg      <= ALU_ZERO;
            a_reg       <= '0;
            b_reg       <= '0;
            res_reg     <= '0;
            carry_reg   <= 1'b0;
            bit_idx_reg <= '0;
            cout_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            res_reg     <= res_next;
            carry_reg   <= carry_next;
            bit_idx_reg <= bit_idx_next;
            cout_reg    <= cout_next;
            ovf_reg     <= ovf_next;
        end
    end

    assign in_ready   = (state_reg == ST_IDLE);
    assign out_valid  = (state_reg == ST_DONE);
    assign out_result = res_reg;
    assign out_cout   = cout_reg;
    assign out_ovf    = ovf_reg;
    assign out_zero   = (res_reg == '0);

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed-vector bench for alu_serial_seq at WIDTH=8.
module tb_alu_serial_seq;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    int checks = 0;
    int errors = 0;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one accept cycle, then scramble the inputs.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
        in_op    = 4'b0101;
        in_a     = 8'h5A;
        in_b     = 8'h3C;
    endtask

    // Wait for out_valid with a cycle budget; returns cycles since accept cycle.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_valid_after_take", 64'(out_valid), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ec, input logic eo);
        int cyc;
        issue(op, a, b);
        wait_done(cyc);
        chk({tag, "_latency"}, 64'(cyc), 64'd9);
        chk({tag, "_result"}, 64'(out_result), 64'(er));
        chk({tag, "_cout"}, 64'(out_cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
        chk({tag, "_zero"}, 64'(out_zero), 64'(er == '0));
        consume();
        $display("op=%b a=%02h b=%02h -> result=%02h cout=%0d ovf=%0d zero=%0d",
                 op, a, b, out_result, out_cout, out_ovf, out_zero);
    endtask

    initial begin
        int cyc;
        logic [W-1:0] held;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 4'b0000; in_a = '0; in_b = '0;
        step(); step();
        rst = 1'b0;
        step();

        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(out_result), 64'd0);
        chk("reset_cout", 64'(out_cout), 64'd0);
        chk("reset_ovf", 64'(out_ovf), 64'd0);
        chk("reset_zero", 64'(out_zero), 64'd1);

        run_op("add_ovf",  ALU_ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        run_op("sub_eq",   ALU_SUB,  8'h05, 8'h05, 8'h00, 1'b1, 1'b0);
        run_op("sub_wrap", ALU_SUB,  8'h00, 8'h01, 8'hFF, 1'b0, 1'b0);
        run_op("slt_neg",  ALU_SLT,  8'h80, 8'h01, 8'h01, 1'b1, 1'b1);
        run_op("sltu",     ALU_SLTU, 8'h80, 8'h01, 8'h00, 1'b1, 1'b0);
        run_op("slt_ovf",  ALU_SLT,  8'h7F, 8'h80, 8'h00, 1'b0, 1'b1);
        run_op("and",      ALU_AND,  8'hC3, 8'hA5, 8'h81, 1'b0, 1'b0);
        run_op("or",       ALU_OR,   8'hC3, 8'hA5, 8'hE7, 1'b0, 1'b0);
        run_op("nor",      ALU_NOR,  8'hC3, 8'hA5, 8'h18, 1'b0, 1'b0);
        run_op("xor",      ALU_XOR,  8'hC3, 8'hA5, 8'h66, 1'b0, 1'b0);
        run_op("xnor",     ALU_XNOR, 8'hC3, 8'hA5, 8'h99, 1'b0, 1'b0);
        run_op("nand",     ALU_NAND, 8'hC3, 8'hA5, 8'h7E, 1'b0, 1'b0);
        run_op("pass_a",   ALU_PASS_A, 8'hC3, 8'hA5, 8'hC3, 1'b0, 1'b0);
        run_op("pass_b",   ALU_PASS_B, 8'hC3, 8'hA5, 8'hA5, 1'b0, 1'b0);
        run_op("zero",     ALU_ZERO, 8'hC3, 8'hA5, 8'h00, 1'b0, 1'b0);
        run_op("op_1111",  4'b1111,  8'hC3, 8'hA5, 8'h00, 1'b0, 1'b0);

        // Backpressure in DONE, plus a stray request driven during RUN.
        issue(ALU_ADD, 8'h21, 8'h12);
        step();
        in_valid = 1'b1; in_op = ALU_OR; in_a = 8'hFF; in_b = 8'hFF;
        chk("run_in_ready", 64'(in_ready), 64'd0);
        step(); step(); step();
        in_valid = 1'b0;
        wait_done(cyc);
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        held = out_result;
        chk("bp_result", 64'(held), 64'h33);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_result", 64'(out_result), 64'(held));
            chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        consume();
        for (int i = 0; i < 12; i++) begin
            step();
            chk("no_second_result", 64'(out_valid), 64'd0);
        end
        $display("backpressure: held result=%02h for 5 cycles", held);

        // Reset mid-RUN at bit index 3.
        issue(ALU_ADD, 8'h55, 8'h33);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", 64'(out_result), 64'd0);
        chk("midrst_zero", 64'(out_zero), 64'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("midrst_no_output", 64'(out_valid), 64'd0);
        end
        $display("mid-run reset: in_ready=%0d out_valid=%0d", in_ready, out_valid);
        run_op("add_after_rst", ALU_ADD, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
